// File: rtl/banked_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : banked_mem_responder
// Description : Four-bank word-interleaved memory responder with per-bank
//               occupancy counters and a fixed-latency read pipeline.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module banked_mem_responder #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_WORDS = 256,
  parameter int BANK_BUSY = 4,
  parameter int RD_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              wr_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              rd_valid_o,
  output logic              stall_o,
  output logic [3:0]        busy_o,
  output logic              err_o
);

  localparam int WIDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W  = 4;

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [CNT_W-1:0]  cnt_q [4];
  logic [CNT_W-1:0]  cnt_d [4];
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  logic              req;
  logic              accept;
  logic [1:0]        bank;
  logic [WIDX_W-1:0] word;
  logic              unused_addr;

  assign bank        = addr_i[2:1];
  assign word        = addr_i[WIDX_W:1];
  assign unused_addr = ^addr_i[ADDR_W-1:WIDX_W+1];

  // An erroring request must never be reported as a stall.
  assign req     = rd_i | wr_i;
  assign err_o   = req & ((rd_i & wr_i) | addr_i[0]);
  assign stall_o = req & ~err_o & busy_o[bank];
  assign accept  = req & ~err_o & ~stall_o;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_bank
      always_comb begin
        cnt_d[i] = cnt_q[i];
        if (accept && (bank == 2'(i))) begin
          cnt_d[i] = CNT_W'(BANK_BUSY);
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_d[i];
        end
      end

      assign busy_o[i] = (cnt_q[i] != '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept & rd_i;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  // Storage and read data stages carry no reset; validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (accept && wr_i) begin
      mem_q[word] <= data_in_i;
    end
    dat_q[0] <= mem_q[word];
    for (int s = 1; s < RD_LAT; s++) begin
      dat_q[s] <= dat_q[s-1];
    end
  end

  assign rd_valid_o = vld_q[RD_LAT-1];
  assign data_out_o = vld_q[RD_LAT-1] ? dat_q[RD_LAT-1] : '0;

endmodule

`default_nettype wire

// File: tb/tb_banked_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_banked_mem_responder
// Description : Directed self-checking bench for banked_mem_responder.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_banked_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] din;
  logic        wr;
  logic        rd;
  logic [15:0] dout;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  banked_mem_responder #(
    .ADDR_W(16), .DATA_W(16), .MEM_WORDS(256), .BANK_BUSY(4), .RD_LAT(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_i     (addr),
    .data_in_i  (din),
    .wr_i       (wr),
    .rd_i       (rd),
    .data_out_o (dout),
    .rd_valid_o (rd_valid),
    .stall_o    (stall),
    .busy_o     (busy),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's request at the falling edge; checks follow 1 time unit later.
  task automatic step(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; din = d;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 4'b0000);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_data_out", dout, 16'h0000);
    chk("rst_stall", stall, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;

    // Write then read back at 0x0010 (bank 0)
    step(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("t1_wr_stall", stall, 1'b0);
    chk("t1_wr_err", err, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("t1_busy_after_wr", busy, 4'b0001);
    end
    step(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("t1_rd_stall", stall, 1'b0);
    chk("t1_busy_free", busy, 4'b0000);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t1_rd_valid_early", rd_valid, 1'b0);
    chk("t1_busy_after_rd", busy, 4'b0001);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t1_rd_valid", rd_valid, 1'b1);
    chk("t1_data", dout, 16'hBEEF);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t1_rd_valid_drop", rd_valid, 1'b0);
    chk("t1_data_zero", dout, 16'h0000);

    // Preload 1..4 across all banks, then consecutive reads
    idle(5);
    step(1'b0, 1'b1, 16'h0000, 16'h0001); chk("t2_wr0_stall", stall, 1'b0);
    step(1'b0, 1'b1, 16'h0002, 16'h0002); chk("t2_wr1_stall", stall, 1'b0);
    step(1'b0, 1'b1, 16'h0004, 16'h0003); chk("t2_wr2_stall", stall, 1'b0);
    step(1'b0, 1'b1, 16'h0006, 16'h0004); chk("t2_wr3_stall", stall, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("t2_rd0_stall", stall, 1'b0);
    chk("t2_rd0_valid", rd_valid, 1'b0);
    step(1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("t2_rd1_stall", stall, 1'b0);
    chk("t2_rd1_valid", rd_valid, 1'b0);
    step(1'b1, 1'b0, 16'h0004, 16'h0000);
    chk("t2_rd2_stall", stall, 1'b0);
    chk("t2_rv0", rd_valid, 1'b1);
    chk("t2_data0", dout, 16'h0001);
    step(1'b1, 1'b0, 16'h0006, 16'h0000);
    chk("t2_rd3_stall", stall, 1'b0);
    chk("t2_rv1", rd_valid, 1'b1);
    chk("t2_data1", dout, 16'h0002);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t2_busy_all", busy, 4'b1111);
    chk("t2_rv2", rd_valid, 1'b1);
    chk("t2_data2", dout, 16'h0003);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t2_rv3", rd_valid, 1'b1);
    chk("t2_data3", dout, 16'h0004);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t2_rv_end", rd_valid, 1'b0);

    // Same-bank conflict: 0x0000 then 0x0008 (both bank 0)
    idle(5);
    step(1'b0, 1'b1, 16'h0008, 16'h5A5A);
    idle(4);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("t3_first_stall", stall, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 16'h0008, 16'h0000);
      chk("t3_conflict_stall", stall, 1'b1);
      chk("t3_conflict_err", err, 1'b0);
      if (k == 1) begin
        chk("t3_first_rv", rd_valid, 1'b1);
        chk("t3_first_data", dout, 16'h0001);
      end
    end
    step(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("t3_second_accept", stall, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t3_second_rv_early", rd_valid, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t3_second_rv", rd_valid, 1'b1);
    chk("t3_second_data", dout, 16'h5A5A);

    // Illegal requests
    idle(5);
    step(1'b1, 1'b1, 16'h0002, 16'hFFFF);
    chk("t4_rdwr_err", err, 1'b1);
    chk("t4_rdwr_stall", stall, 1'b0);
    step(1'b1, 1'b0, 16'h0003, 16'h0000);
    chk("t4_odd_err", err, 1'b1);
    chk("t4_odd_stall", stall, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t4_busy_none", busy, 4'b0000);
    chk("t4_no_rv", rd_valid, 1'b0);
    step(1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("t4_readback_stall", stall, 1'b0);
    step(1'b1, 1'b0, 16'h0003, 16'h0000);
    chk("t4_err_busy_bank", err, 1'b1);
    chk("t4_no_stall_busy_bank", stall, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t4_readback_rv", rd_valid, 1'b1);
    chk("t4_storage_kept", dout, 16'h0002);

    // Reset while a read is in flight
    idle(5);
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("t5_rd_stall", stall, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t5_busy_before_rst", busy, 4'b0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy_in_rst", busy, 4'b0000);
    chk("t5_rv_in_rst", rd_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; rd = 1'b1; addr = 16'h0000;
    #1;
    chk("t5_new_rd_stall", stall, 1'b0);
    chk("t5_old_rv_dropped", rd_valid, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t5_rv_still_0", rd_valid, 1'b0);
    chk("t5_busy_new", busy, 4'b0001);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t5_new_rv", rd_valid, 1'b1);
    chk("t5_new_data", dout, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
